// File: rtl/gate_state_mac_seq.sv
// Sequential complex gate x state MAC over sign-magnitude words.
// Define GSM_SATURATE_EN to saturate out-of-range results (default: wrap).
module gate_state_mac_seq #(
  parameter int NQ    = 2,
  parameter int WIDTH = 8,
  parameter int FRAC  = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [(1<<NQ)*(1<<NQ)*WIDTH-1:0]  gate_re,
  input  logic [(1<<NQ)*(1<<NQ)*WIDTH-1:0]  gate_im,
  input  logic [(1<<NQ)*WIDTH-1:0]          state_re,
  input  logic [(1<<NQ)*WIDTH-1:0]          state_im,
  output logic                              busy,
  output logic                              done,
  output logic [(1<<NQ)*WIDTH-1:0]          out_re,
  output logic [(1<<NQ)*WIDTH-1:0]          out_im,
  output logic                              overflow
);

  localparam int DIM = 1 << NQ;
  localparam int AW  = WIDTH + NQ + 2;
  localparam int PW  = 2 * WIDTH;
  localparam int XW  = PW + AW;
  localparam logic [XW-1:0] MAXM = XW'(2**(WIDTH-1) - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [NQ-1:0]    row;
  logic [NQ-1:0]    col;
  logic signed [AW-1:0] acc_re;
  logic signed [AW-1:0] acc_im;

  logic [WIDTH-1:0] gr [DIM*DIM];
  logic [WIDTH-1:0] gi [DIM*DIM];
  logic [WIDTH-1:0] sr [DIM];
  logic [WIDTH-1:0] si [DIM];

  logic signed [XW-1:0] ar, ai, br, bi;
  logic signed [XW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [XW-1:0] sum_re, sum_im;
  logic [WIDTH:0]       cr, ci;

  function automatic logic signed [XW-1:0] tc(
    input logic [WIDTH-1:0] w
  );
    logic signed [XW-1:0] m;
    m = $signed({{(XW-WIDTH+1){1'b0}}, w[WIDTH-2:0]});
    return w[WIDTH-1] ? -m : m;
  endfunction

  // Result is {overflow, sign, magnitude}; zero always comes out as +0.
  function automatic logic [WIDTH:0] to_sm(
    input logic signed [XW-1:0] v
  );
    logic             neg;
    logic [XW-1:0]    m;
    logic             ov;
    logic [WIDTH-2:0] o;
    neg = v[XW-1];
    m   = neg ? -v : v;
    ov  = m > MAXM;
`ifdef GSM_SATURATE_EN
    o = ov ? '1 : m[WIDTH-2:0];
`else
    o = m[WIDTH-2:0];
`endif
    return {ov, neg && (o != '0), o};
  endfunction

  always_comb begin
    ar = tc(gr[{row, col}]);
    ai = tc(gi[{row, col}]);
    br = tc(sr[col]);
    bi = tc(si[col]);
    p_rr = (ar * br) >>> FRAC;
    p_ii = (ai * bi) >>> FRAC;
    p_ri = (ar * bi) >>> FRAC;
    p_ir = (ai * br) >>> FRAC;
    sum_re = {{PW{acc_re[AW-1]}}, acc_re}
           + (p_rr - p_ii);
    sum_im = {{PW{acc_im[AW-1]}}, acc_im}
           + (p_ri + p_ir);
    cr = to_sm(sum_re);
    ci = to_sm(sum_im);
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      overflow <= 1'b0;
      out_re   <= '0;
      out_im   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < DIM*DIM; i++) begin
              gr[i] <= gate_re[i*WIDTH +: WIDTH];
              gi[i] <= gate_im[i*WIDTH +: WIDTH];
            end
            for (int i = 0; i < DIM; i++) begin
              sr[i] <= state_re[i*WIDTH +: WIDTH];
              si[i] <= state_im[i*WIDTH +: WIDTH];
            end
            overflow <= 1'b0;
            row      <= '0;
            col      <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          if (&col) begin
            out_re[row*WIDTH +: WIDTH] <= cr[WIDTH-1:0];
            out_im[row*WIDTH +: WIDTH] <= ci[WIDTH-1:0];
            overflow <= overflow | cr[WIDTH] | ci[WIDTH];
            acc_re   <= '0;
            acc_im   <= '0;
            col      <= '0;
            row      <= row + NQ'(1);
            if (&row) state <= DONE;
          end else begin
            acc_re <= sum_re[AW-1:0];
            acc_im <= sum_im[AW-1:0];
            col    <= col + NQ'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_state_mac_seq.sv
// Directed bench for gate_state_mac_seq (NQ=1, WIDTH=8, FRAC=6).
// Arithmetic model plus hand-computed literal pins.
module tb_gate_state_mac_seq;

  localparam int NQ = 1;
  localparam int W  = 8;
  localparam int D  = 2;
  localparam int DD = D * D;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [DD*W-1:0] gate_re, gate_im;
  logic [D*W-1:0]  state_re, state_im;
  logic            busy, done, overflow;
  logic [D*W-1:0]  out_re, out_im;

  gate_state_mac_seq #(.NQ(NQ), .WIDTH(W), .FRAC(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .gate_re(gate_re), .gate_im(gate_im),
    .state_re(state_re), .state_im(state_im),
    .busy(busy), .done(done),
    .out_re(out_re), .out_im(out_im),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit live    = 0;

  int             rem = 0;
  logic [D*W-1:0] exp_re = '0, exp_im = '0;
  logic           exp_ovf = 1'b0;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int sm(input logic [7:0] w);
    int m;
    m = int'(w[6:0]);
    return w[7] ? -m : m;
  endfunction

  function automatic logic [8:0] conv(input int v);
    int m, o;
    bit ov;
    m  = (v < 0) ? -v : v;
    ov = m > 127;
`ifdef GSM_SATURATE_EN
    o = ov ? 127 : m;
`else
    o = m % 128;
`endif
    return {ov, (v < 0) && (o != 0), 7'(o)};
  endfunction

  // Whole matrix-vector product at once, from the current inputs.
  task automatic model();
    int sre, sim, ar, ai, br, bi;
    logic [8:0] cr, ci;
    exp_ovf = 1'b0;
    for (int r = 0; r < D; r++) begin
      sre = 0;
      sim = 0;
      for (int c = 0; c < D; c++) begin
        ar = sm(gate_re[(r*D+c)*W +: W]);
        ai = sm(gate_im[(r*D+c)*W +: W]);
        br = sm(state_re[c*W +: W]);
        bi = sm(state_im[c*W +: W]);
        sre += ((ar*br) >>> 6) - ((ai*bi) >>> 6);
        sim += ((ar*bi) >>> 6) + ((ai*br) >>> 6);
      end
      cr = conv(sre);
      ci = conv(sim);
      exp_re[r*W +: W] = cr[7:0];
      exp_im[r*W +: W] = ci[7:0];
      exp_ovf = exp_ovf | cr[8] | ci[8];
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      rem     = 0;
      exp_re  = '0;
      exp_im  = '0;
      exp_ovf = 1'b0;
    end else if (rem > 0) begin
      rem--;
    end else if (start) begin
      model();
      rem = DD + 1;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("busy", 16'(busy), 16'(rem > 0));
      check("done", 16'(done), 16'(rem == 1));
      if (rem == 0) begin
        check("out_re", out_re, exp_re);
        check("out_im", out_im, exp_im);
        check("overflow", 16'(overflow), 16'(exp_ovf));
      end
    end
  end

  task automatic set_in(input logic [31:0] gr, input logic [31:0] gi,
                        input logic [15:0] sr, input logic [15:0] si);
    gate_re  = gr;
    gate_im  = gi;
    state_re = sr;
    state_im = si;
  endtask

  task automatic run();
    int n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 16'(n), 16'(DD + 1));
    @(negedge clk);
  endtask

  logic [7:0] big;
  bit         saw_done;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_in('0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    live = 1;
    @(negedge clk) reset = 1'b0;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_out", out_re, 16'h0000);

    set_in(32'h40000040, '0, 16'h0040, 16'h0000);
    run();
    check("s1_re", out_re, 16'h0040);
    check("s1_im", out_im, 16'h0000);
    check("s1_ovf", 16'(overflow), 16'd0);

    set_in(32'h00404000, '0, 16'h1020, 16'h0500);
    run();
    check("s2_re", out_re, 16'h2010);
    check("s2_im", out_im, 16'h0005);

    set_in(32'hAD2D2D2D, '0, 16'h0040, 16'h0000);
    run();
    check("s3_re", out_re, 16'h2D2D);
    check("s3_im", out_im, 16'h0000);

    set_in('1, '0, '1, '0);
    gate_re  = {4{8'h7F}};
    state_re = {2{8'h7F}};
    run();
`ifdef GSM_SATURATE_EN
    big = 8'h7F;
`else
    big = 8'h78;
`endif
    check("s4_re", out_re, {big, big});
    check("s4_ovf", 16'(overflow), 16'd1);

    set_in('0, 32'h0040C000, 16'h0040, 16'h0000);
    run();
    check("s5_re", out_re, 16'h0000);
    check("s5_im", out_im, 16'h4000);
    check("s5_ovf", 16'(overflow), 16'd0);

    set_in(32'hC00000C0, '0, 16'h8580, 16'h0013);
    run();
    check("neg_re", out_re, 16'h0500);
    check("neg_im", out_im, 16'h0093);

    set_in(32'hAD2D2D2D, '0, 16'h0305, 16'h0000);
    run();
    check("trunc_re", out_re, 16'h0005);

    // Restart attempt plus input change while busy must not disturb the run.
    set_in(32'h40000040, '0, 16'h0011, 16'h0022);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) begin
      start = 1'b1;
      set_in(32'h00404000, '0, 16'h3333, 16'h4444);
    end
    @(negedge clk) start = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 4 && !saw_done; i++) begin
      if (done) saw_done = 1;
      else @(negedge clk);
    end
    check("rb_done", 16'(saw_done), 16'd1);
    @(negedge clk);
    check("rb_re", out_re, 16'h0011);
    check("rb_im", out_im, 16'h0022);

    // Reset during the second MAC cycle.
    set_in(32'h00404000, '0, 16'h1020, 16'h0500);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("mr_busy", 16'(busy), 16'd0);
    check("mr_out", out_re, 16'h0000);
    check("mr_ovf", 16'(overflow), 16'd0);
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    check("mr_nodone", 16'(saw_done), 16'd0);

    // Reset wins over start.
    @(negedge clk) begin
      reset = 1'b1;
      start = 1'b1;
    end
    @(negedge clk) begin
      reset = 1'b0;
      start = 1'b0;
    end
    check("prio_busy", 16'(busy), 16'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/gate_state_mac_seq.md
GATE_STATE_MAC_SEQ -- requirements
Module: gate_state_mac_seq

Interface
REQ-001 SHALL have parameter NQ, default 2, meaning qubit count; DIM = 2**NQ.
REQ-002 SHALL have parameter WIDTH, default 8, meaning the sign-magnitude word width (MSB = sign).
REQ-003 SHALL have parameter FRAC, default 6, meaning the fraction bits in each word.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request a gate-times-state product.
REQ-007 SHALL have ports gate_re and gate_im, input, DIM*DIM*WIDTH bits each: element [r][c] at word index r*DIM+c.
REQ-008 SHALL have ports state_re and state_im, input, DIM*WIDTH bits each: element [c] at word index c.
REQ-009 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a result is complete.
REQ-011 SHALL have ports out_re and out_im, output, DIM*WIDTH bits each: the result vector.
REQ-012 SHALL have port overflow, output, 1 bit: sticky result-overflow flag for the last run.

Function
REQ-013 SHALL implement a state machine with states IDLE, MAC, DONE.
REQ-014 In IDLE, start=1 SHALL do all of: capture gate_* and state_* into internal registers, clear overflow, set row=col=0, clear the accumulator, enter MAC.
REQ-015 Each MAC cycle SHALL add gate[row][col]*state[col] (complex multiply: re = ar*br - ai*bi, im = ar*bi + ai*br) into the accumulator.
REQ-016 When col=DIM-1, the same MAC cycle SHALL do all of: write the converted accumulator to out[row], clear the accumulator, set col=0, increment row.
REQ-017 The MAC cycle with row=DIM-1 and col=DIM-1 SHALL move the machine to DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-018 Latency: with start sampled at edge t, done SHALL be high in the cycle after edge t+DIM*DIM, i.e. DIM*DIM+1 cycles after start.
REQ-019 busy SHALL be 1 in MAC and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Input words SHALL be converted from sign-magnitude to two's complement.
REQ-022 Each real partial product SHALL be formed at 2*WIDTH bits and arithmetically shifted right by FRAC, truncating.
REQ-023 The accumulator SHALL be two's complement of WIDTH+NQ+2 bits and SHALL never overflow internally.
REQ-024 Conversion to output SHALL produce sign-magnitude WIDTH bits; a magnitude above 2**(WIDTH-1)-1 SHALL set overflow.
REQ-025 A zero result SHALL be output as +0; a -0 input SHALL be treated as 0.
REQ-026 out_re/out_im SHALL hold their previous value until overwritten row by row, and are valid from the done pulse until the next start.

Reset
REQ-027 reset=1 at any edge, including mid-MAC, SHALL force IDLE, row=col=0, accumulator=0, busy=0, done=0, overflow=0, out_re=out_im=0.
REQ-028 reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro GSM_SATURATE_EN: when defined, an out-of-range output magnitude SHALL saturate to 2**(WIDTH-1)-1 with its sign kept.
REQ-030 Without GSM_SATURATE_EN, the output magnitude SHALL be the low WIDTH-1 bits of the true magnitude (wrap); overflow SHALL be flagged identically in both builds.

Verification
REQ-031 Scenario 1 (NQ=1, WIDTH=8, FRAC=6): identity gate (0x40 diagonal), state re={0x40,0x00} -> out_re={0x40,0x00}, out_im=0, done 5 cycles after start, overflow=0.
REQ-032 Scenario 2 (same config): Pauli-X (0x40 off-diagonal), state re={0x20,0x10}, im={0x00,0x05} -> out_re={0x10,0x20}, out_im={0x05,0x00}.
REQ-033 Scenario 3 (same config): Hadamard (0x2D, 0x2D, 0x2D, 0xAD), state re={0x40,0} -> out_re={0x2D,0x2D}, out_im=0.
REQ-034 Scenario 4 (same config): all gate_re=0x7F, all state_re=0x7F -> overflow=1; out_re word = 0x7F with GSM_SATURATE_EN, 0x78 without.
REQ-035 Scenario 5 (same config): Pauli-Y (im: [0][1]=0xC0, [1][0]=0x40), state re={0x40,0} -> out_re=0, out_im={0x00,0x40}.
REQ-036 Scenario 6: pulse start again while busy -> no restart, done at the original cycle; assert reset at the 2nd MAC cycle -> next cycle has busy=0, outputs 0, and no done pulse.
